// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount greedily from ten/five/one coin tubes
// through a hopper handshake, with per-tube refill and a hopper-ack timeout.
module change_dispenser #(
  parameter logic [4:0] ONE         = 5'd1,
  parameter logic [4:0] FIVE        = 5'd5,
  parameter logic [4:0] TEN         = 5'd10,
  parameter logic [3:0] STOCK_INIT  = 4'd8,
  parameter logic [4:0] ACK_TIMEOUT = 5'd20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [4:0] req_amount,
  output logic       req_ready,
  output logic       coin_valid,
  output logic [4:0] coin_denom,
  input  logic       coin_ack,
  input  logic       refill,
  input  logic [4:0] refill_denom,
  input  logic [3:0] refill_count,
  output logic       done,
  output logic       short,
  output logic [4:0] short_amount,
  output logic       fault,
  output logic [3:0] stock_ten,
  output logic [3:0] stock_five,
  output logic [3:0] stock_one
);

  localparam int unsigned AMT_W = 5;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMR_W = 5;

  typedef enum logic [2:0] {IDLE, SELECT, PAY, DONE, FAULT} state_e;
  typedef enum logic [1:0] {C_NONE, C_TEN, C_FIVE, C_ONE} coin_e;

  state_e             state_q, state_d;
  coin_e              coin_q, coin_d;
  logic [AMT_W-1:0]   remaining_q, remaining_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   ten_d, five_d, one_d;
  logic               short_d;
  logic [AMT_W-1:0]   short_amount_d;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  function automatic logic [AMT_W-1:0] coin_value(input coin_e c);
    case (c)
      C_TEN:   return TEN;
      C_FIVE:  return FIVE;
      C_ONE:   return ONE;
      default: return '0;
    endcase
  endfunction

  // Next-state, datapath and tube bookkeeping
  always_comb begin
    state_d        = state_q;
    coin_d         = coin_q;
    remaining_d    = remaining_q;
    timer_d        = timer_q;
    ten_d          = stock_ten;
    five_d         = stock_five;
    one_d          = stock_one;
    short_d        = short;
    short_amount_d = short_amount;
    case (state_q)
      IDLE: begin
        if (refill) begin
          if (refill_denom == TEN)       ten_d  = sat_add(stock_ten, refill_count);
          else if (refill_denom == FIVE) five_d = sat_add(stock_five, refill_count);
          else if (refill_denom == ONE)  one_d  = sat_add(stock_one, refill_count);
        end
        if (req_valid) begin
          state_d        = SELECT;
          remaining_d    = req_amount;
          short_d        = 1'b0;
          short_amount_d = '0;
        end
      end
      SELECT: begin
        timer_d = '0;
        if (remaining_q == '0) begin
          state_d = DONE;
        end else if (TEN <= remaining_q && stock_ten != '0) begin
          coin_d  = C_TEN;
          state_d = PAY;
        end else if (FIVE <= remaining_q && stock_five != '0) begin
          coin_d  = C_FIVE;
          state_d = PAY;
        end else if (ONE <= remaining_q && stock_one != '0) begin
          coin_d  = C_ONE;
          state_d = PAY;
        end else begin
          state_d        = DONE;
          short_d        = 1'b1;
          short_amount_d = remaining_q;
        end
      end
      PAY: begin
        if (coin_ack) begin
          remaining_d = remaining_q - coin_value(coin_q);
          case (coin_q)
            C_TEN:   ten_d  = stock_ten - CNT_W'(1);
            C_FIVE:  five_d = stock_five - CNT_W'(1);
            C_ONE:   one_d  = stock_one - CNT_W'(1);
            default: ;
          endcase
          state_d = SELECT;
        end else if ((TMR_W + 1)'(timer_q) + (TMR_W + 1)'(1) >= (TMR_W + 1)'(ACK_TIMEOUT)) begin
          state_d = FAULT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs; outputs follow the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      coin_q       <= C_NONE;
      remaining_q  <= '0;
      timer_q      <= '0;
      stock_ten    <= STOCK_INIT;
      stock_five   <= STOCK_INIT;
      stock_one    <= STOCK_INIT;
      short        <= 1'b0;
      short_amount <= '0;
      req_ready    <= 1'b1;
      coin_valid   <= 1'b0;
      coin_denom   <= '0;
      done         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state_q      <= state_d;
      coin_q       <= coin_d;
      remaining_q  <= remaining_d;
      timer_q      <= timer_d;
      stock_ten    <= ten_d;
      stock_five   <= five_d;
      stock_one    <= one_d;
      short        <= short_d;
      short_amount <= short_amount_d;
      req_ready    <= (state_d == IDLE);
      coin_valid   <= (state_d == PAY);
      coin_denom   <= (state_d == PAY) ? coin_value(coin_d) : '0;
      done         <= (state_d == DONE);
      fault        <= (state_d == FAULT);
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a default instance and a STOCK_INIT=2 instance share
// stimulus; a selector routes requests/acks to one of them at a time.
module tb_change_dispenser;

  logic clk = 1'b0;
  logic reset, sel;
  logic req_valid, coin_ack, refill;
  logic [4:0] req_amount, refill_denom;
  logic [3:0] refill_count;

  logic a_req_valid, a_coin_ack, a_refill, b_req_valid, b_coin_ack, b_refill;
  logic a_req_ready, a_coin_valid, a_done, a_short, a_fault;
  logic b_req_ready, b_coin_valid, b_done, b_short, b_fault;
  logic [4:0] a_coin_denom, a_short_amount, b_coin_denom, b_short_amount;
  logic [3:0] a_stock_ten, a_stock_five, a_stock_one, b_stock_ten, b_stock_five, b_stock_one;

  logic o_req_ready, o_coin_valid, o_done, o_short, o_fault;
  logic [4:0] o_coin_denom, o_short_amount;
  logic [3:0] o_stock_ten, o_stock_five, o_stock_one;

  always #5 clk = ~clk;

  assign a_req_valid = req_valid & ~sel;
  assign a_coin_ack  = coin_ack & ~sel;
  assign a_refill    = refill & ~sel;
  assign b_req_valid = req_valid & sel;
  assign b_coin_ack  = coin_ack & sel;
  assign b_refill    = refill & sel;

  assign o_req_ready    = sel ? b_req_ready    : a_req_ready;
  assign o_coin_valid   = sel ? b_coin_valid   : a_coin_valid;
  assign o_coin_denom   = sel ? b_coin_denom   : a_coin_denom;
  assign o_done         = sel ? b_done         : a_done;
  assign o_short        = sel ? b_short        : a_short;
  assign o_short_amount = sel ? b_short_amount : a_short_amount;
  assign o_fault        = sel ? b_fault        : a_fault;
  assign o_stock_ten    = sel ? b_stock_ten    : a_stock_ten;
  assign o_stock_five   = sel ? b_stock_five   : a_stock_five;
  assign o_stock_one    = sel ? b_stock_one    : a_stock_one;

  change_dispenser dut_a (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_amount(req_amount),
    .req_ready(a_req_ready), .coin_valid(a_coin_valid), .coin_denom(a_coin_denom),
    .coin_ack(a_coin_ack), .refill(a_refill), .refill_denom(refill_denom),
    .refill_count(refill_count), .done(a_done), .short(a_short),
    .short_amount(a_short_amount), .fault(a_fault), .stock_ten(a_stock_ten),
    .stock_five(a_stock_five), .stock_one(a_stock_one)
  );

  change_dispenser #(.STOCK_INIT(4'd2)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_amount(req_amount),
    .req_ready(b_req_ready), .coin_valid(b_coin_valid), .coin_denom(b_coin_denom),
    .coin_ack(b_coin_ack), .refill(b_refill), .refill_denom(refill_denom),
    .refill_count(refill_count), .done(b_done), .short(b_short),
    .short_amount(b_short_amount), .fault(b_fault), .stock_ten(b_stock_ten),
    .stock_five(b_stock_five), .stock_one(b_stock_one)
  );

  typedef struct {
    int amount;
    bit ref_en;
    int ref_denom;
    int ref_count;
    int exp_n;
    bit exp_short;
    int exp_samt;
    int exp_t;
    int exp_f;
    int exp_o;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int m_stock[3];
  int coin_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Greedy reference: queue the coins the tubes should deliver for this amount
  function automatic void model_req(input int amount);
    int vals[3];
    int rem;
    bit found;
    vals = '{10, 5, 1};
    rem = amount;
    do begin
      found = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (!found && rem != 0 && vals[i] <= rem && m_stock[i] > 0) begin
          found = 1'b1;
          rem -= vals[i];
          m_stock[i]--;
          coin_q.push_back(vals[i]);
        end
      end
    end while (found);
  endfunction

  function automatic void model_refill(input int denom, input int count);
    int idx;
    idx = (denom == 10) ? 0 : (denom == 5) ? 1 : (denom == 1) ? 2 : -1;
    if (idx >= 0) m_stock[idx] = (m_stock[idx] + count > 15) ? 15 : m_stock[idx] + count;
  endfunction

  task automatic do_reset(input int init);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0; coin_ack = 1'b0; refill = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_stock = '{init, init, init};
    coin_q.delete();
  endtask

  task automatic run_req(input vec_t v);
    int cycles, ncoins, first_at;
    bit done_seen;
    check("ready_before_req", o_req_ready, 1);
    if (v.ref_en) model_refill(v.ref_denom, v.ref_count);
    model_req(v.amount);
    req_valid = 1'b1; req_amount = 5'(v.amount);
    refill = v.ref_en; refill_denom = 5'(v.ref_denom); refill_count = 4'(v.ref_count);
    @(posedge clk); #1;
    req_valid = 1'b0; refill = 1'b0;
    cycles = 0; ncoins = 0; first_at = -1; done_seen = 1'b0;
    while (!done_seen && cycles < 200) begin
      @(negedge clk);
      if (o_done) begin
        done_seen = 1'b1;
      end else if (o_coin_valid) begin
        if (first_at < 0) first_at = cycles;
        ncoins++;
        if (coin_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL extra_coin: got denom %0d expected none (amount %0d)", o_coin_denom, v.amount);
        end else begin
          check("coin_denom", o_coin_denom, coin_q.pop_front());
        end
        coin_ack = 1'b1;
        @(posedge clk); #1;
        coin_ack = 1'b0;
      end
      cycles++;
    end
    check("done_seen", done_seen, 1);
    check("coin_count", ncoins, v.exp_n);
    if (v.exp_n > 0) check("first_coin_latency", first_at, 1);
    check("coins_left", coin_q.size(), 0);
    coin_q.delete();
    check("short", o_short, v.exp_short);
    check("short_amount", o_short_amount, v.exp_samt);
    check("stock_ten", o_stock_ten, v.exp_t);
    check("stock_five", o_stock_five, v.exp_f);
    check("stock_one", o_stock_one, v.exp_o);
    @(negedge clk);
    check("done_one_cycle", o_done, 0);
    check("ready_after", o_req_ready, 1);
    check("short_held", o_short, v.exp_short);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tab_a[6];
    vec_t tab_b[3];
    int cnt, cycles, dones;
    //            amt ref dn cnt  n sh samt  t  f  o
    tab_a[0] = '{18, 0, 0, 0,  5, 0, 0,  7, 7, 5};
    tab_a[1] = '{ 0, 0, 0, 0,  0, 0, 0,  7, 7, 5};
    tab_a[2] = '{27, 0, 0, 0,  5, 0, 0,  5, 6, 3};
    tab_a[3] = '{ 9, 0, 0, 0,  4, 1, 1,  5, 5, 0};
    tab_a[4] = '{ 3, 0, 0, 0,  0, 1, 3,  5, 5, 0};
    tab_a[5] = '{20, 0, 0, 0,  2, 0, 0,  3, 5, 0};
    tab_b[0] = '{31, 0, 0, 0,  5, 0, 0,  0, 0, 1};
    tab_b[1] = '{12, 0, 0, 0,  1, 1, 11, 0, 0, 0};
    tab_b[2] = '{10, 1, 10, 1, 1, 0, 0,  0, 0, 0};

    sel = 1'b0; reset = 1'b0;
    req_valid = 1'b0; req_amount = '0; coin_ack = 1'b0;
    refill = 1'b0; refill_denom = '0; refill_count = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", o_req_ready, 1);
    check("rst_coin_valid", o_coin_valid, 0);
    check("rst_coin_denom", o_coin_denom, 0);
    check("rst_done", o_done, 0);
    check("rst_short", o_short, 0);
    check("rst_short_amount", o_short_amount, 0);
    check("rst_fault", o_fault, 0);
    check("rst_stock_ten", o_stock_ten, 8);
    check("rst_stock_five", o_stock_five, 8);
    check("rst_stock_one", o_stock_one, 8);
    check("rst_b_stock_one", b_stock_one, 2);
    reset = 1'b1;
    @(negedge clk);
    m_stock = '{8, 8, 8};

    foreach (tab_a[i]) run_req(tab_a[i]);

    sel = 1'b1;
    m_stock = '{2, 2, 2};
    foreach (tab_b[i]) run_req(tab_b[i]);
    sel = 1'b0;

    // Zero request: done two edges after accept, no coin
    do_reset(8);
    req_valid = 1'b1; req_amount = 5'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("zero_done_edge1", o_done, 0);
    check("zero_cv_edge1", o_coin_valid, 0);
    @(posedge clk); #1;
    check("zero_done_edge2", o_done, 1);
    check("zero_cv_edge2", o_coin_valid, 0);
    check("zero_short", o_short, 0);
    @(posedge clk); #1;
    check("zero_done_edge3", o_done, 0);
    check("zero_ready_edge3", o_req_ready, 1);

    // Refill in IDLE: saturation, bad denomination, stray ack
    @(negedge clk);
    refill = 1'b1; refill_denom = 5'd5; refill_count = 4'd10;
    @(posedge clk); #1;
    refill = 1'b0;
    check("refill_five_sat", o_stock_five, 15);
    @(negedge clk);
    refill = 1'b1; refill_denom = 5'd7; refill_count = 4'd3;
    @(posedge clk); #1;
    refill = 1'b0;
    check("refill_bad_ten", o_stock_ten, 8);
    check("refill_bad_five", o_stock_five, 15);
    check("refill_bad_one", o_stock_one, 8);
    @(negedge clk);
    coin_ack = 1'b1;
    @(posedge clk); #1;
    coin_ack = 1'b0;
    check("idle_ack_five", o_stock_five, 15);
    check("idle_ack_ready", o_req_ready, 1);

    // Refill during PAY is ignored
    @(negedge clk);
    req_valid = 1'b1; req_amount = 5'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pay_cv", o_coin_valid, 1);
    check("pay_denom", o_coin_denom, 5);
    refill = 1'b1; refill_denom = 5'd1; refill_count = 4'd3;
    @(posedge clk); #1;
    refill = 1'b0;
    @(negedge clk);
    check("pay_refill_one", o_stock_one, 8);
    check("pay_hold_cv", o_coin_valid, 1);
    check("pay_hold_denom", o_coin_denom, 5);
    coin_ack = 1'b1;
    @(posedge clk); #1;
    coin_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pay_done", o_done, 1);
    check("pay_stock_five", o_stock_five, 14);
    check("pay_stock_one", o_stock_one, 8);
    @(negedge clk);

    // Hopper never acks: FAULT after ACK_TIMEOUT PAY cycles
    req_valid = 1'b1; req_amount = 5'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cnt = 0; cycles = 0;
    while (!o_fault && cycles < 100) begin
      @(negedge clk);
      if (o_coin_valid) cnt++;
      cycles++;
    end
    check("timeout_fault", o_fault, 1);
    check("timeout_pay_cycles", cnt, 20);
    check("fault_cv", o_coin_valid, 0);
    req_valid = 1'b1;
    repeat (5) @(negedge clk);
    req_valid = 1'b0;
    check("fault_ready", o_req_ready, 0);
    check("fault_held", o_fault, 1);
    check("fault_cv_held", o_coin_valid, 0);

    // Reset in the middle of PAY
    do_reset(8);
    check("post_fault_reset", o_fault, 0);
    req_valid = 1'b1; req_amount = 5'd10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midpay_cv_before", o_coin_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("midpay_cv_async", o_coin_valid, 0);
    check("midpay_ready", o_req_ready, 1);
    check("midpay_done", o_done, 0);
    check("midpay_stock_ten", o_stock_ten, 8);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_done || o_coin_valid) dones++;
    end
    check("midpay_no_done", dones, 0);
    check("midpay_ready_after", o_req_ready, 1);
    m_stock = '{8, 8, 8};
    coin_q.delete();
    run_req(tab_a[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
